miriscv_lsu_hs: RTL
===================

MIRISCV_LSU_HS -- requirements
Module: miriscv_lsu_hs

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning memory/core data width; legal values 32 and 64.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning maximum cycles waited for grant or response before a bus error; range 1..65535.
REQ-003 SHALL have ports, clock and reset first:
- clk_i  in  1  clock, rising edge.
- arstn_i  in  1  reset, asynchronous, active-high.
- lsu_req_i  in  1  core access request, held until the stall drops.
- lsu_we_i  in  1  1 = store.
- lsu_size_i  in  3  0=B, 1=H, 2=W, 3=D (DATA_W=64 only), 4=BU, 5=HU, 6=WU (DATA_W=64 only).
- lsu_addr_i  in  32  byte address.
- lsu_data_i  in  DATA_W  store data, LSB-aligned.
- lsu_stall_req_o  out  1  pipeline stall.
- lsu_data_o  out  DATA_W  load result, extended per size.
- lsu_err_o  out  1  one-cycle pulse: misaligned or timeout.
- data_req_o  out  1  memory request.
- data_gnt_i  in  1  memory accepted request this cycle.
- data_rvalid_i  in  1  response valid (read data or write ack).
- data_rdata_i  in  DATA_W  read data.
- data_we_o  out  1  write enable.
- data_be_o  out  DATA_W/8  byte enables.
- data_addr_o  out  32  address aligned to DATA_W/8.
- data_wdata_o  out  DATA_W  store data shifted to byte lane.

Function
REQ-004 SHALL implement FSM IDLE, REQ1, RSP1, REQ2, RSP2, DONE.
REQ-005 IDLE: on lsu_req_i, latch address, size, we and data, then go to REQ1; if the access is illegal (REQ-014) go to DONE with error instead.
REQ-006 REQ1/REQ2: data_req_o=1 with stable address, be, we and wdata until the cycle data_gnt_i=1, then go to RSP1/RSP2.
REQ-007 RSP1/RSP2: data_req_o=0; on data_rvalid_i, capture rdata; RSP1 goes to REQ2 if the access is split, else DONE; RSP2 goes to DONE.
REQ-008 DONE lasts exactly one cycle: lsu_stall_req_o=0, lsu_data_o valid, lsu_err_o valid; next state IDLE. A new lsu_req_i is sampled only in IDLE.
REQ-009 lsu_stall_req_o SHALL be 1 whenever lsu_req_i=1 and state is not DONE, including the IDLE acceptance cycle. Minimum latency: request to DONE = 3 cycles with zero-wait grant and response.
REQ-010 data_be_o SHALL have size-many contiguous ones shifted by addr mod (DATA_W/8); data_wdata_o SHALL be lsu_data_i shifted left by 8 x offset.
REQ-011 Loads SHALL right-shift captured data by offset, then sign-extend (B, H, W) or zero-extend (BU, HU, WU) to DATA_W; stores drive lsu_data_o=0.
REQ-012 A wait counter SHALL reset on entry to each REQ/RSP state; reaching TIMEOUT cycles SHALL go to DONE with lsu_err_o=1 and data_req_o dropped.
REQ-013 data_rvalid_i asserted in IDLE or REQ states SHALL be ignored.
REQ-014 Sizes D/WU with DATA_W=32, and size codes 7, SHALL be illegal: no memory access, lsu_err_o=1.

Reset
REQ-015 arstn_i=1 SHALL force IDLE and counter=0; outputs data_req_o=0, lsu_stall_req_o=lsu_req_i, lsu_err_o=0, lsu_data_o=0, data_be_o=0.
REQ-016 Reset mid-transaction SHALL abandon it immediately; late gnt/rvalid are ignored per REQ-013.

Configuration
REQ-017 Macro MIRISCV_LSU_MISALIGN_SPLIT_EN: when defined, an access crossing a DATA_W/8 boundary SHALL be split into two transactions (REQ1 lower word, REQ2 address+DATA_W/8) with merged be/data; when undefined, any misaligned access SHALL go IDLE->DONE with lsu_err_o=1 and no data_req_o.

Verification
REQ-018 DATA_W=32, LB from 0x103 with gnt and rvalid immediate, rdata=0x80AABBCC -> be=1000, lsu_data_o=0xFFFFFF80, stall drops on cycle 3.
REQ-019 SH of 0x1234 to 0x202, gnt delayed 4 cycles -> req held 5 cycles, be=1100, wdata=0x12340000, addr 0x200.
REQ-020 LW from 0x0FE, SPLIT_EN defined, rdata 0xAAAA0000 then 0x0000BBBB -> two requests (0x0FC, 0x100), lsu_data_o=0xBBBBAAAA; SPLIT_EN undefined -> lsu_err_o pulse, zero requests.
REQ-021 TIMEOUT=8, no gnt -> lsu_err_o pulse on the 9th cycle after acceptance, data_req_o=0.
REQ-022 arstn_i pulsed while in RSP1, then rvalid arrives -> state IDLE, no DONE, lsu_data_o=0.
REQ-023 DATA_W=64, LWU from 0x104, rdata=0xF0000000_00000000 -> be=0xF0, lsu_data_o=0x00000000_F0000000.

Source files
------------

// File: rtl/miriscv_lsu_hs.sv
// Load/store unit: turns core load/store requests into gnt/rvalid data-bus transactions.
// Define MIRISCV_LSU_MISALIGN_SPLIT_EN to split boundary-crossing accesses into two bus transactions.
module miriscv_lsu_hs #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic [2:0]            lsu_size_i,
  input  logic [31:0]           lsu_addr_i,
  input  logic [DATA_W-1:0]     lsu_data_i,
  output logic                  lsu_stall_req_o,
  output logic [DATA_W-1:0]     lsu_data_o,
  output logic                  lsu_err_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  input  logic [DATA_W-1:0]     data_rdata_i,
  output logic                  data_we_o,
  output logic [DATA_W/8-1:0]   data_be_o,
  output logic [31:0]           data_addr_o,
  output logic [DATA_W-1:0]     data_wdata_o
);

  localparam int NB   = DATA_W / 8;
  localparam int OFFW = $clog2(NB);
  localparam int BE2  = 2 * NB;

  typedef enum logic [2:0] {IDLE, REQ1, RSP1, REQ2, RSP2, DONE} state_e;

  state_e              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [31:0]         addr_q, addr_d;
  logic [2:0]          size_q, size_d;
  logic                we_q, we_d;
  logic [BE2-1:0]      be_q, be_d;
  logic [2*DATA_W-1:0] wdata_q, wdata_d;
  logic [2*DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                err_q, err_d;

  function automatic logic [3:0] size_bytes(input logic [2:0] s);
    case (s)
      3'd0, 3'd4: return 4'd1;
      3'd1, 3'd5: return 4'd2;
      3'd2, 3'd6: return 4'd4;
      default:    return 4'd8;
    endcase
  endfunction

  function automatic logic size_illegal(input logic [2:0] s);
    return (s == 3'd7) || ((DATA_W == 32) && ((s == 3'd3) || (s == 3'd6)));
  endfunction

  // Byte lanes and data are laid out over two bus words so a crossing access shows its upper part.
  logic [OFFW-1:0]     in_off;
  logic [3:0]          in_bytes;
  logic [BE2-1:0]      in_be;
  logic [2*DATA_W-1:0] in_wdata;
  logic                in_cross, in_bad;

  assign in_off   = lsu_addr_i[OFFW-1:0];
  assign in_bytes = size_bytes(lsu_size_i);
  assign in_be    = ((BE2'(1) << in_bytes) - BE2'(1)) << in_off;
  assign in_wdata = {{DATA_W{1'b0}}, lsu_data_i} << {in_off, 3'b000};
  assign in_cross = |in_be[BE2-1:NB];

`ifdef MIRISCV_LSU_MISALIGN_SPLIT_EN
  assign in_bad = size_illegal(lsu_size_i);
`else
  assign in_bad = size_illegal(lsu_size_i) || in_cross;
`endif

  logic [2*DATA_W-1:0] rsp_merged, rsp_shifted;
  logic [DATA_W-1:0]   raw, mask, ld_result;
  logic [6:0]          nbits;
  logic                sign_bit;

  assign rsp_merged  = (state_q == RSP2) ? {data_rdata_i, rdata_q[DATA_W-1:0]}
                                         : {rdata_q[2*DATA_W-1:DATA_W], data_rdata_i};
  assign rsp_shifted = rsp_merged >> {addr_q[OFFW-1:0], 3'b000};
  assign raw         = rsp_shifted[DATA_W-1:0];
  assign nbits       = {size_bytes(size_q), 3'b000};
  assign mask        = ~({DATA_W{1'b1}} << nbits);
  assign sign_bit    = |(raw & (DATA_W'(1) << (nbits - 7'd1)));
  assign ld_result   = (raw & mask) | (((size_q < 3'd4) && sign_bit) ? ~mask : '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    data_d  = data_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (lsu_req_i) begin
          addr_d  = lsu_addr_i;
          size_d  = lsu_size_i;
          we_d    = lsu_we_i;
          be_d    = in_be;
          wdata_d = in_wdata;
          rdata_d = '0;
          if (in_bad) begin
            state_d = DONE;
            err_d   = 1'b1;
            data_d  = '0;
          end else begin
            state_d = REQ1;
          end
        end
      end
      REQ1, REQ2: begin
        if (data_gnt_i) begin
          state_d = (state_q == REQ1) ? RSP1 : RSP2;
          cnt_d   = '0;
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          state_d = DONE;
          err_d   = 1'b1;
          data_d  = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RSP1, RSP2: begin
        if (data_rvalid_i) begin
          rdata_d = rsp_merged;
          cnt_d   = '0;
          if ((state_q == RSP1) && (|be_q[BE2-1:NB])) begin
            state_d = REQ2;
          end else begin
            state_d = DONE;
            data_d  = we_q ? '0 : ld_result;
          end
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          state_d = DONE;
          err_d   = 1'b1;
          data_d  = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arstn_i) begin
    if (arstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign data_req_o      = (state_q == REQ1) || (state_q == REQ2);
  assign data_we_o       = data_req_o && we_q;
  assign data_be_o       = (state_q == REQ1) ? be_q[NB-1:0] :
                           (state_q == REQ2) ? be_q[BE2-1:NB] : '0;
  assign data_wdata_o    = (state_q == REQ1) ? wdata_q[DATA_W-1:0] :
                           (state_q == REQ2) ? wdata_q[2*DATA_W-1:DATA_W] : '0;
  assign data_addr_o     = {addr_q[31:OFFW], {OFFW{1'b0}}} + ((state_q == REQ2) ? 32'(NB) : 32'd0);
  assign lsu_stall_req_o = lsu_req_i && (state_q != DONE);
  assign lsu_data_o      = data_q;
  assign lsu_err_o       = err_q;

endmodule
